// File: rtl/uart_tx_fifo_ser.sv
// uart_tx_fifo_ser: 8N1 UART transmitter with a 16-entry write-side FIFO.
// A bus master pushes bytes with we/di. The serialiser pops them in order
// and shifts each one out LSB first on txd, sending frames back-to-back
// while the FIFO has data.
//
// Handshake: we is a push request. It is accepted on a rising edge only when
// full_flag is low. A push while full is silently dropped, and there is no
// other backpressure. full_flag is registered, so a pop in the same cycle
// does not make room for that push.
module uart_tx_fifo_ser #(
  parameter int DIV      = 434,
  parameter int FIFO_AW  = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         di,
  input  logic               we,
  output logic               txd,
  output logic               busy,
  output logic [FIFO_AW:0]   count,
  output logic               empty_flag,
  output logic               afull_flag,
  output logic               full_flag,
  output logic [1:0]         fsm_state
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CNT_W = FIFO_AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // FIFO storage and pointers
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [CNT_W-1:0]   count_d;
  logic               push;
  logic               pop;

  // Serialiser state
  state_t      state;
  state_t      state_d;
  logic [15:0] timer;
  logic [15:0] timer_d;
  logic [2:0]  bit_idx;
  logic [2:0]  bit_idx_d;
  logic [7:0]  shift;
  logic [7:0]  shift_d;
  logic        txd_d;
  logic        bit_last;

  assign push      = we && !full_flag;
  assign bit_last  = (timer == 16'(DIV - 1));
  assign busy      = (state != IDLE);
  assign fsm_state = state;

  // FIFO RAM write port; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= di;
    end
  end

  // Occupancy for the next cycle; flags are derived from it so they move with count
  always_comb begin
    count_d = count;
    case ({push, pop})
      2'b10:   count_d = count + CNT_W'(1);
      2'b01:   count_d = count - CNT_W'(1);
      default: count_d = count;
    endcase
  end

  // Serialiser next-state logic; txd is computed here and registered, so it is glitch-free
  always_comb begin
    state_d   = state;
    timer_d   = timer + 16'd1;
    bit_idx_d = bit_idx;
    shift_d   = shift;
    txd_d     = txd;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        timer_d = 16'd0;
        txd_d   = 1'b1;
        if (!empty_flag) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          state_d = START;
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (bit_last) begin
          timer_d   = 16'd0;
          bit_idx_d = 3'd0;
          state_d   = DATA;
          txd_d     = shift[0];
        end
      end
      DATA: begin
        if (bit_last) begin
          timer_d = 16'd0;
          shift_d = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
            txd_d     = shift[1];
          end
        end
      end
      STOP: begin
        if (bit_last) begin
          timer_d = 16'd0;
          if (!empty_flag) begin
            // Back-to-back frame: reload straight into START with no idle gap
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            state_d = START;
            txd_d   = 1'b0;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = 16'd0;
        txd_d   = 1'b1;
      end
    endcase
  end

  // State, pointer, count and flag registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= 16'd0;
      bit_idx    <= 3'd0;
      shift      <= 8'd0;
      txd        <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      empty_flag <= 1'b1;
      afull_flag <= 1'b0;
      full_flag  <= 1'b0;
    end else begin
      state      <= state_d;
      timer      <= timer_d;
      bit_idx    <= bit_idx_d;
      shift      <= shift_d;
      txd        <= txd_d;
      if (push) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      count      <= count_d;
      empty_flag <= (count_d == '0);
      afull_flag <= (count_d >= CNT_W'(AF_LEVEL));
      full_flag  <= (count_d == CNT_W'(DEPTH));
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_ser.sv
// tb_uart_tx_fifo_ser: directed bench for the UART TX FIFO serialiser.
// A txd monitor decodes every frame and checks it against a queue of expected bytes.
module tb_uart_tx_fifo_ser;

  localparam int DIV      = 4;
  localparam int FIFO_AW  = 4;
  localparam int AF_LEVEL = 12;
  localparam int FRAME    = 10 * DIV;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             we  = 1'b0;
  logic [7:0]       di  = 8'h00;
  logic             txd;
  logic             busy;
  logic [FIFO_AW:0] count;
  logic             empty_flag;
  logic             afull_flag;
  logic             full_flag;
  logic [1:0]       fsm_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];

  uart_tx_fifo_ser #(
    .DIV      (DIV),
    .FIFO_AW  (FIFO_AW),
    .AF_LEVEL (AF_LEVEL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .di         (di),
    .we         (we),
    .txd        (txd),
    .busy       (busy),
    .count      (count),
    .empty_flag (empty_flag),
    .afull_flag (afull_flag),
    .full_flag  (full_flag),
    .fsm_state  (fsm_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
    end
  endtask

  // One clock: return 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b, input bit expect_tx);
    we = 1'b1;
    di = b;
    if (expect_tx) exp_q.push_back(b);
    tick();
    we = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (!(busy === 1'b0 && empty_flag === 1'b1) && n < max_cyc) begin
      tick();
      n++;
    end
    check_eq("idle_timeout", n < max_cyc, 1);
  endtask

  // txd monitor: samples once per cycle, checks frame shape and decodes the byte
  initial begin : monitor
    int         idx;
    int         seg;
    bit         in_frame;
    bit         ok;
    logic [7:0] data;
    idx      = 0;
    seg      = 0;
    in_frame = 1'b0;
    ok       = 1'b1;
    data     = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        in_frame = 1'b0;
      end else begin
        if (!in_frame && txd === 1'b0) begin
          in_frame = 1'b1;
          idx      = 0;
          ok       = 1'b1;
          data     = 8'h00;
          start_q.push_back(cyc);
        end
        if (in_frame) begin
          seg = idx / DIV;
          if (busy !== 1'b1) ok = 1'b0;
          if (seg == 0) begin
            if (txd !== 1'b0) ok = 1'b0;
          end else if (seg == 9) begin
            if (txd !== 1'b1) ok = 1'b0;
          end else if (idx % DIV == 0) begin
            data[seg-1] = txd;
          end else if (txd !== data[seg-1]) begin
            ok = 1'b0;
          end
          idx++;
          if (idx == FRAME) begin
            in_frame = 1'b0;
            check_eq("frame_fmt", ok, 1);
            if (exp_q.size() == 0) check_eq("rx_unexpected", exp_q.size(), 1);
            else check_eq("rx_byte", data, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin : stimulus
    int n_starts;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check_eq("rst_txd", txd, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_empty", empty_flag, 1);
    check_eq("rst_afull", afull_flag, 0);
    check_eq("rst_full", full_flag, 0);
    rst = 1'b0;
    tick();

    // Single byte 0x55: count 1 after write, popped next edge, txd falls then
    write_byte(8'h55, 1'b1);
    check_eq("t1_count_wr", count, 1);
    check_eq("t1_empty_wr", empty_flag, 0);
    check_eq("t1_txd_wr", txd, 1);
    tick();
    check_eq("t1_count_pop", count, 0);
    check_eq("t1_empty_pop", empty_flag, 1);
    check_eq("t1_txd_start", txd, 0);
    check_eq("t1_busy", busy, 1);
    wait_idle(100);
    check_eq("t1_drained", exp_q.size(), 0);

    // Two bytes on consecutive cycles go out back-to-back
    start_q.delete();
    we = 1'b1;
    di = 8'hA3;
    exp_q.push_back(8'hA3);
    tick();
    di = 8'h0F;
    exp_q.push_back(8'h0F);
    tick();
    we = 1'b0;
    wait_idle(200);
    check_eq("t2_drained", exp_q.size(), 0);
    check_eq("t2_frames", start_q.size(), 2);
    if (start_q.size() >= 2) check_eq("t2_gap", start_q[1] - start_q[0], FRAME);

    // Fill: 0xEE starts a frame, then 0x00..0x10 are written while it is shifting.
    // Nothing pops for 40 cycles, so 0x00..0x0F fill the FIFO and 0x10 is dropped.
    write_byte(8'hEE, 1'b1);           // E0
    tick();                            // E0+1: 0xEE popped
    for (int k = 0; k < 17; k++) begin // E0+2 .. E0+18
      write_byte(8'(k), k < 16);
      check_eq("t3_count", count, (k < 16) ? k + 1 : 16);
      check_eq("t3_afull", afull_flag, ((k < 16) ? k + 1 : 16) >= AF_LEVEL);
      check_eq("t3_full", full_flag, k >= 15);
    end
    repeat (22) tick();                // E0+40: last STOP cycle of 0xEE
    check_eq("t3_full_hold", full_flag, 1);
    check_eq("t3_count_hold", count, 16);
    // Write on the same edge as the STOP-end pop: dropped, count 16 -> 15
    write_byte(8'h77, 1'b0);           // E0+41
    check_eq("t4_count_simul", count, 15);
    check_eq("t4_full_simul", full_flag, 0);
    check_eq("t4_afull_simul", afull_flag, 1);
    wait_idle(1000);
    check_eq("t3_drained", exp_q.size(), 0);

    // Wrap-around: 3 rounds of 10 bytes
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) begin
        write_byte(8'(r * 10 + i) ^ 8'hC5, 1'b1);
      end
      wait_idle(600);
    end
    check_eq("t5_count", count, 0);
    check_eq("t5_empty", empty_flag, 1);
    check_eq("t5_drained", exp_q.size(), 0);

    // count=5 with an accepted write on the pop edge: count stays 5
    write_byte(8'h11, 1'b1);           // E0
    tick();                            // E0+1 pop
    for (int i = 0; i < 5; i++) write_byte(8'h20 + 8'(i), 1'b1); // E0+2..E0+6
    check_eq("t6_count5", count, 5);
    repeat (34) tick();                // E0+40
    check_eq("t6_count5_pre", count, 5);
    write_byte(8'h99, 1'b1);           // E0+41 pop + write
    check_eq("t6_count5_simul", count, 5);
    wait_idle(400);
    check_eq("t6_drained", exp_q.size(), 0);

    // Reset during DATA bit 3 with 3 bytes queued
    write_byte(8'hB0, 1'b0);           // E0
    tick();                            // E0+1 pop
    for (int i = 0; i < 3; i++) write_byte(8'hC0 + 8'(i), 1'b0); // E0+2..E0+4
    repeat (13) tick();                // E0+17: inside DATA bit 3
    check_eq("t7_pre_busy", busy, 1);
    check_eq("t7_pre_count", count, 3);
    rst = 1'b1;
    tick();                            // E0+18
    rst = 1'b0;
    check_eq("t7_txd", txd, 1);
    check_eq("t7_busy", busy, 0);
    check_eq("t7_count", count, 0);
    check_eq("t7_empty", empty_flag, 1);
    check_eq("t7_full", full_flag, 0);
    n_starts = start_q.size();
    repeat (100) tick();
    check_eq("t7_no_frames", start_q.size(), n_starts);
    check_eq("t7_txd_idle", txd, 1);
    write_byte(8'h81, 1'b1);
    wait_idle(100);
    check_eq("t7_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
